// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: instruction field widths, opcode constants and the
// program loader state encoding.
package mcpu_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int OPCODE_SIZE  = 4;
  localparam int OPERAND_SIZE = WORD_SIZE - OPCODE_SIZE;

  localparam logic [OPCODE_SIZE-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_SIZE-1:0] OP_ADD = 4'h1;
  localparam logic [OPCODE_SIZE-1:0] OP_SUB = 4'h2;
  localparam logic [OPCODE_SIZE-1:0] OP_JMP = 4'h5;
  localparam logic [OPCODE_SIZE-1:0] OP_LDI = 4'h7;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_CLEAR = 2'd1,
    LD_LOAD  = 2'd2,
    LD_RUN   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/mcpu_prog_loader.sv
// Program loader: holds the MCPU in reset, optionally zeroes program RAM, streams
// words from a valid/ready source into RAM, then releases the CPU.
module mcpu_prog_loader #(
  parameter int WORD_SIZE     = mcpu_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH    = 8,
  parameter int RAM_SIZE      = 256,
  parameter bit CLEAR_ON_LOAD = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_SIZE-1:0]  in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

  import mcpu_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   LAST_WORD = (ADDR_WIDTH + 1)'(RAM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   SIZE_W    = (ADDR_WIDTH + 1)'(RAM_SIZE);

  ld_state_e             state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_SIZE-1:0]  ram_wdata_q, ram_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  accept, launch;

  assign accept = in_valid & in_ready_q;
  assign launch = start & ((state_q == LD_IDLE) | (state_q == LD_RUN));

  // NOTE: every *_d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;
    count_d     = count_q;

    case (state_q)
      LD_CLEAR: begin
        ram_wdata_d = '0;
        if (ram_addr_q == LAST_ADDR) begin
          state_d = LD_LOAD;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = ram_addr_q + 1'b1;
        end
      end
      LD_LOAD: begin
        if (accept) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = count_q[ADDR_WIDTH-1:0];
          ram_wdata_d = in_data;
          count_d     = count_q + 1'b1;
          if (in_last) begin
            state_d = LD_RUN;
          end else if (count_q == LAST_WORD) begin
            state_d = LD_RUN;
            err_d   = 1'b1;
          end
        end
      end
      LD_RUN: begin
        // The final write is on the port during the first RUN cycle, so the
        // CPU is released only one cycle later.
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
      end
      default: ;
    endcase

    if (launch) begin
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
      err_d       = 1'b0;
      count_d     = '0;
      if (CLEAR_ON_LOAD) begin
        state_d     = LD_CLEAR;
        ram_we_d    = 1'b1;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
      end else begin
        state_d = LD_LOAD;
      end
    end

    in_ready_d = (state_d == LD_LOAD) && (count_d < SIZE_W);
    busy_d     = (state_d == LD_CLEAR) || (state_d == LD_LOAD);
  end

  // NOTE: state registers use non-blocking assignments; the RAM contents are
  // deliberately untouched by reset, only the control/port registers are.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LD_IDLE;
      in_ready_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Scoreboard bench for mcpu_prog_loader: a 256-word clearing instance and an
// 8-word non-clearing instance, expected RAM writes queued and popped by a monitor.
module tb_mcpu_prog_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset     [2];
  logic        start     [2];
  logic [15:0] in_data   [2];
  logic        in_valid  [2];
  logic        in_last   [2];
  logic        in_ready  [2];
  logic        ram_we    [2];
  logic [7:0]  ram_addr  [2];
  logic [15:0] ram_wdata [2];
  logic        cpu_reset [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err_ovf   [2];
  logic [8:0]  word_count[2];

  wr_t         exp_q0[$];
  wr_t         exp_q1[$];
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mcpu_prog_loader #(.WORD_SIZE(16), .ADDR_WIDTH(8), .RAM_SIZE(256), .CLEAR_ON_LOAD(1'b1)) dut_a (
    .clk(clk), .reset(reset[0]), .start(start[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
    .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .cpu_reset(cpu_reset[0]), .busy(busy[0]), .done(done[0]),
    .err_overflow(err_ovf[0]), .word_count(word_count[0])
  );

  mcpu_prog_loader #(.WORD_SIZE(16), .ADDR_WIDTH(8), .RAM_SIZE(8), .CLEAR_ON_LOAD(1'b0)) dut_b (
    .clk(clk), .reset(reset[1]), .start(start[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
    .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .cpu_reset(cpu_reset[1]), .busy(busy[1]), .done(done[1]),
    .err_overflow(err_ovf[1]), .word_count(word_count[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int sel);
    wr_t e;
    if ((sel == 0 && exp_q0.size() == 0) || (sel == 1 && exp_q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write dut%0d: addr 0x%0h data 0x%0h, expected none",
               sel, ram_addr[sel], ram_wdata[sel]);
      return;
    end
    if (sel == 0) begin
      e = exp_q0.pop_front();
      mem0[ram_addr[0]] = ram_wdata[0];
    end else begin
      e = exp_q1.pop_front();
      mem1[ram_addr[1][2:0]] = ram_wdata[1];
    end
    check($sformatf("wr_addr dut%0d", sel), 32'(ram_addr[sel]), 32'(e.addr));
    check($sformatf("wr_data dut%0d", sel), 32'(ram_wdata[sel]), 32'(e.data));
  endtask

  always @(negedge clk) begin
    if (ram_we[0] === 1'b1) sb_pop(0);
    if (ram_we[1] === 1'b1) sb_pop(1);
  end

  task automatic pulse_start(input int sel);
    @(negedge clk);
    start[sel] = 1'b1;
    @(posedge clk);
    #1 start[sel] = 1'b0;
  endtask

  // Idle cycles carry junk data/last with valid low; they must be ignored.
  task automatic send(input int sel, input logic [15:0] d, input logic last,
                      input int gap, input int budget, output bit acc);
    acc = 1'b0;
    in_data[sel] = 16'hDEAD;
    in_last[sel] = 1'b1;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid[sel] = 1'b1;
    in_data[sel]  = d;
    in_last[sel]  = last;
    for (int i = 0; i < budget; i++) begin
      if (in_ready[sel]) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) #1;
    in_valid[sel] = 1'b0;
    in_last[sel]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int cnt;
    int busy_bad;
    for (int s = 0; s < 2; s++) begin
      reset[s] = 1'b1; start[s] = 1'b0; in_data[s] = '0; in_valid[s] = 1'b0; in_last[s] = 1'b0;
    end

    // 1: reset held two cycles, start ignored, nothing written
    start[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset[0]), 1);
    check("rst_done", 32'(done[0]), 0);
    check("rst_ram_we", 32'(ram_we[0]), 0);
    check("rst_in_ready", 32'(in_ready[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_word_count", 32'(word_count[0]), 0);
    check("rst_addr", 32'(ram_addr[1]), 0);
    start[0] = 1'b0;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    check("idle_cpu_reset", 32'(cpu_reset[0]), 1);

    // 2: clear 256 words, busy throughout, then ready
    for (int i = 0; i < 256; i++) exp_q0.push_back('{addr: 8'(i), data: 16'h0000});
    exp_q0.push_back('{addr: 8'd0, data: 16'h7013});
    exp_q0.push_back('{addr: 8'd1, data: 16'h71EE});
    exp_q0.push_back('{addr: 8'd2, data: 16'h7308});
    pulse_start(0);
    cnt = 0;
    busy_bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready[0]) break;
      cnt++;
      if (busy[0] !== 1'b1) busy_bad++;
    end
    check("clear_cycles", 32'(cnt), 256);
    check("clear_busy_low_cycles", 32'(busy_bad), 0);
    check("load_busy", 32'(busy[0]), 1);
    check("load_cpu_reset", 32'(cpu_reset[0]), 1);

    // 3: three words with valid gaps, last on the third
    send(0, 16'h7013, 1'b0, 2, 10, acc); check("acc_w0", 32'(acc), 1);
    send(0, 16'h71EE, 1'b0, 3, 10, acc); check("acc_w1", 32'(acc), 1);
    send(0, 16'h7308, 1'b1, 1, 10, acc); check("acc_w2", 32'(acc), 1);
    @(negedge clk);
    check("final_write_we", 32'(ram_we[0]), 1);
    check("final_write_cpu_reset", 32'(cpu_reset[0]), 1);
    check("final_write_done", 32'(done[0]), 0);
    check("final_in_ready", 32'(in_ready[0]), 0);
    @(negedge clk);
    check("run_cpu_reset", 32'(cpu_reset[0]), 0);
    check("run_done", 32'(done[0]), 1);
    check("run_busy", 32'(busy[0]), 0);
    check("run_word_count", 32'(word_count[0]), 3);
    check("run_err", 32'(err_ovf[0]), 0);
    check("fetch_addr0", 32'(mem0[0]), 32'h7013);
    check("ram_addr2", 32'(mem0[2]), 32'h7308);
    check("ram_addr3_cleared", 32'(mem0[3]), 32'h0000);

    // 4: RAM_SIZE=8, ten words without last -> overflow after eight
    for (int i = 0; i < 8; i++) exp_q1.push_back('{addr: 8'(i), data: 16'hA000 + 16'(i)});
    pulse_start(1);
    @(negedge clk);
    check("b_load_ready", 32'(in_ready[1]), 1);
    check("b_load_busy", 32'(busy[1]), 1);
    for (int i = 0; i < 7; i++) begin
      send(1, 16'hA000 + 16'(i), 1'b0, 0, 10, acc);
      check($sformatf("b_acc_%0d", i), 32'(acc), 1);
    end
    send(1, 16'hA007, 1'b0, 0, 10, acc);
    check("b_acc_7", 32'(acc), 1);
    @(negedge clk);
    check("ovf_in_ready", 32'(in_ready[1]), 0);
    check("ovf_err", 32'(err_ovf[1]), 1);
    check("ovf_word_count", 32'(word_count[1]), 8);
    send(1, 16'hA008, 1'b0, 0, 4, acc); check("ovf_no_acc_8", 32'(acc), 0);
    send(1, 16'hA009, 1'b0, 0, 4, acc); check("ovf_no_acc_9", 32'(acc), 0);
    check("ovf_done", 32'(done[1]), 1);
    check("ovf_cpu_reset", 32'(cpu_reset[1]), 0);
    check("ovf_err_sticky", 32'(err_ovf[1]), 1);

    // 5: start in RUN reloads two words and clears the error
    exp_q1.push_back('{addr: 8'd0, data: 16'h1111});
    exp_q1.push_back('{addr: 8'd1, data: 16'h2222});
    pulse_start(1);
    @(negedge clk);
    check("reload_cpu_reset", 32'(cpu_reset[1]), 1);
    check("reload_done", 32'(done[1]), 0);
    check("reload_err_clr", 32'(err_ovf[1]), 0);
    check("reload_count_clr", 32'(word_count[1]), 0);
    send(1, 16'h1111, 1'b0, 0, 10, acc); check("reload_acc0", 32'(acc), 1);
    send(1, 16'h2222, 1'b1, 1, 10, acc); check("reload_acc1", 32'(acc), 1);
    repeat (2) @(negedge clk);
    check("reload_word_count", 32'(word_count[1]), 2);
    check("reload_done_again", 32'(done[1]), 1);
    check("reload_cpu_run", 32'(cpu_reset[1]), 0);
    check("reload_err", 32'(err_ovf[1]), 0);

    // 6: reset in the middle of a load
    for (int i = 0; i < 5; i++) exp_q1.push_back('{addr: 8'(i), data: 16'h3300 + 16'(i)});
    pulse_start(1);
    for (int i = 0; i < 5; i++) begin
      send(1, 16'h3300 + 16'(i), 1'b0, 0, 10, acc);
      check($sformatf("abort_acc_%0d", i), 32'(acc), 1);
    end
    @(posedge clk);
    #1 reset[1] = 1'b1;
    @(negedge clk);
    check("abort_cpu_reset", 32'(cpu_reset[1]), 1);
    check("abort_word_count", 32'(word_count[1]), 0);
    check("abort_busy", 32'(busy[1]), 0);
    check("abort_in_ready", 32'(in_ready[1]), 0);
    check("abort_ram_we", 32'(ram_we[1]), 0);
    for (int i = 0; i < 5; i++)
      check($sformatf("abort_ram_%0d", i), 32'(mem1[i]), 32'h3300 + 32'(i));
    reset[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_stays_idle", 32'(in_ready[1]), 0);

    check("sb_empty_a", 32'(exp_q0.size()), 0);
    check("sb_empty_b", 32'(exp_q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
